// File: rtl/maxnet_param.sv
// maxnet_param: MaxNet winner-take-all over N unsigned W-bit channels with start/done handshake.
// Define MAXNET_TIMEOUT_EN to add the MAX_ITER iteration limit and the `timeout` output.
module maxnet_param #(
  parameter int N         = 4,
  parameter int W         = 5,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 15,
  localparam int IW       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  x,
  output logic [W-1:0]    max,
  output logic [IW-1:0]   max_idx,
  output logic            done,
  output logic            busy,
  output logic            tie
`ifdef MAXNET_TIMEOUT_EN
  , output logic          timeout
`endif
);

  localparam int SW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  acc      [N];
  logic [W-1:0]  orig     [N];
  logic [W-1:0]  next_acc [N];
  logic [SW-1:0] inh      [N];
  logic [SW-1:0] sum;
  logic [CW-1:0] nz_cnt;
  logic [W-1:0]  best;
  logic [IW-1:0] win;
  logic          same, next_zero;
  logic          load, update, finish;

`ifdef MAXNET_TIMEOUT_EN
  localparam int KW = $clog2(MAX_ITER + 1);
  logic [KW-1:0] k;
  logic          to_hit;
`else
  localparam int unused_max_iter = MAX_ITER;
`endif

  // Inhibition step plus the survivor count and lowest-index argmax on the registered acc.
  always_comb begin
    sum       = '0;
    nz_cnt    = '0;
    best      = '0;
    win       = '0;
    same      = 1'b1;
    next_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      sum = sum + SW'(acc[i]);
      if (acc[i] != '0) nz_cnt = nz_cnt + CW'(1);
      if (acc[i] > best) begin
        best = acc[i];
        win  = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      inh[i]      = (sum - SW'(acc[i])) >> EPS_SHIFT;
      next_acc[i] = (SW'(acc[i]) > inh[i]) ? (acc[i] - inh[i][W-1:0]) : '0;
      if (next_acc[i] != acc[i]) same = 1'b0;
      if (next_acc[i] != '0) next_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    update     = 1'b0;
    finish     = 1'b0;
`ifdef MAXNET_TIMEOUT_EN
    to_hit     = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_ITER;
        end
      end
      S_ITER: begin
        // Covers single survivor, all-zero, stall, and an update that would wipe every channel.
        if (nz_cnt <= CW'(1) || same || next_zero) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
`ifdef MAXNET_TIMEOUT_EN
        else if (k == KW'(MAX_ITER)) begin
          finish     = 1'b1;
          to_hit     = 1'b1;
          state_next = S_DONE;
        end
`endif
        else begin
          update = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        acc[i]  <= '0;
        orig[i] <= '0;
      end
      max     <= '0;
      max_idx <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      tie     <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
      k       <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      if (load) begin
        for (int i = 0; i < N; i++) begin
          acc[i]  <= x[i*W +: W];
          orig[i] <= x[i*W +: W];
        end
        max     <= '0;
        max_idx <= '0;
        done    <= 1'b0;
        busy    <= 1'b1;
        tie     <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
        k       <= '0;
        timeout <= 1'b0;
`endif
      end
      if (update) begin
        for (int i = 0; i < N; i++) acc[i] <= next_acc[i];
`ifdef MAXNET_TIMEOUT_EN
        k <= k + KW'(1);
`endif
      end
      if (finish) begin
        max     <= orig[win];
        max_idx <= win;
        tie     <= (nz_cnt != CW'(1));
        done    <= 1'b1;
        busy    <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
        timeout <= to_hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_maxnet_param.sv
// Self-checking bench for maxnet_param: scoreboard of expected results popped when done rises.
module tb_maxnet_param;

  localparam int W = 5;

  typedef struct {
    logic [4:0] mx;
    logic [1:0] idx;
    logic       tie;
    logic       to;
    int         edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] x = '0;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  logic [W-1:0] max_a, max_z, max_t, max_m;
  logic [1:0]   idx_a, idx_z, idx_t, idx_m;
  logic         done_a, done_z, done_t, done_m;
  logic         busy_a, busy_z, busy_t, busy_m;
  logic         tie_a, tie_z, tie_t, tie_m;
  logic         to_a, to_z, to_t, to_m;

  always #5 clk = ~clk;

  maxnet_param #(.N(4), .W(5), .EPS_SHIFT(2), .MAX_ITER(15)) dut_a (
    .clk(clk), .rst(rst), .start(start), .x(x), .max(max_a), .max_idx(idx_a),
    .done(done_a), .busy(busy_a), .tie(tie_a)
`ifdef MAXNET_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  maxnet_param #(.N(4), .W(5), .EPS_SHIFT(0), .MAX_ITER(15)) dut_z (
    .clk(clk), .rst(rst), .start(start), .x(x), .max(max_z), .max_idx(idx_z),
    .done(done_z), .busy(busy_z), .tie(tie_z)
`ifdef MAXNET_TIMEOUT_EN
    , .timeout(to_z)
`endif
  );

  maxnet_param #(.N(4), .W(5), .EPS_SHIFT(2), .MAX_ITER(2)) dut_t (
    .clk(clk), .rst(rst), .start(start), .x(x), .max(max_t), .max_idx(idx_t),
    .done(done_t), .busy(busy_t), .tie(tie_t)
`ifdef MAXNET_TIMEOUT_EN
    , .timeout(to_t)
`endif
  );

`ifndef MAXNET_TIMEOUT_EN
  assign to_a = 1'b0;
  assign to_z = 1'b0;
  assign to_t = 1'b0;
`endif

  always_comb begin
    case (sel)
      1: begin max_m = max_z; idx_m = idx_z; done_m = done_z; busy_m = busy_z; tie_m = tie_z; to_m = to_z; end
      2: begin max_m = max_t; idx_m = idx_t; done_m = done_t; busy_m = busy_t; tie_m = tie_t; to_m = to_t; end
      default: begin max_m = max_a; idx_m = idx_a; done_m = done_a; busy_m = busy_a; tie_m = tie_a; to_m = to_a; end
    endcase
  end

  function automatic logic [19:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  function automatic exp_t mk(input int mx, input int idx, input bit t, input bit to, input int e);
    exp_t r;
    r.mx = 5'(mx); r.idx = 2'(idx); r.tie = t; r.to = to; r.edge_n = e;
    return r;
  endfunction

  // Returns at the falling edge right after the accepting edge (edge 0).
  task automatic do_start(input logic [19:0] xv, input int gap, input bit push, input exp_t e);
    repeat (gap) @(negedge clk);
    if (push) sb.push_back(e);
    @(negedge clk);
    x = xv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = index of the edge after which done was seen; poke>0 pulses a bogus start mid-run.
  task automatic wait_done(input int poke, output int n);
    n = 0;
    while (done_m !== 1'b1 && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == poke) begin
        start = 1'b1;
        x = pk(31, 31, 31, 31);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({max_a, idx_a, done_a, busy_a, tie_a, to_a} !== 12'b0) begin
      n_bad++; $display("FAIL reset_a: got %h want 0", {max_a, idx_a, done_a, busy_a, tie_a, to_a});
    end
    n_cmp++;
    if ({max_z, idx_z, done_z, busy_z, tie_z, to_z} !== 12'b0) begin
      n_bad++; $display("FAIL reset_z: got %h want 0", {max_z, idx_z, done_z, busy_z, tie_z, to_z});
    end
    n_cmp++;
    if ({max_t, idx_t, done_t, busy_t, tie_t, to_t} !== 12'b0) begin
      n_bad++; $display("FAIL reset_t: got %h want 0", {max_t, idx_t, done_t, busy_t, tie_t, to_t});
    end
    rst = 1'b0;
  endtask

  task automatic test_converge;
    int n;
    exp_t e;
    sel = 0;
    do_start(pk(8, 6, 4, 2), 2, 1'b1, mk(8, 0, 0, 0, 5));
    n_cmp++;
    if (busy_m !== 1'b1 || done_m !== 1'b0) begin
      n_bad++; $display("FAIL conv_busy: got busy=%b done=%b want busy=1 done=0", busy_m, done_m);
    end
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m} !== {e.mx, e.idx, e.tie, e.to}) begin
      n_bad++; $display("FAIL conv_result: got max=%0d idx=%0d tie=%b to=%b want max=%0d idx=%0d tie=%b to=%b",
                        max_m, idx_m, tie_m, to_m, e.mx, e.idx, e.tie, e.to);
    end
    n_cmp++;
    if (n !== e.edge_n) begin
      n_bad++; $display("FAIL conv_latency: got edge %0d want %0d", n, e.edge_n);
    end
  endtask

  task automatic test_stall;
    int n;
    exp_t e;
    sel = 0;
    do_start(pk(1, 1, 0, 0), 0, 1'b1, mk(1, 0, 1, 0, 1));
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m} !== {e.mx, e.idx, e.tie, e.to}) begin
      n_bad++; $display("FAIL stall_result: got max=%0d idx=%0d tie=%b to=%b want max=%0d idx=%0d tie=%b to=%b",
                        max_m, idx_m, tie_m, to_m, e.mx, e.idx, e.tie, e.to);
    end
    n_cmp++;
    if (n !== e.edge_n) begin
      n_bad++; $display("FAIL stall_latency: got edge %0d want %0d", n, e.edge_n);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    exp_t e;
    sel = 0;
    do_start(pk(0, 0, 0, 0), 0, 1'b1, mk(0, 0, 1, 0, 1));
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m, n} !== {e.mx, e.idx, e.tie, e.to, e.edge_n}) begin
      n_bad++; $display("FAIL zero_result: got max=%0d idx=%0d tie=%b edge=%0d want max=%0d idx=%0d tie=%b edge=%0d",
                        max_m, idx_m, tie_m, n, e.mx, e.idx, e.tie, e.edge_n);
    end
    do_start(pk(0, 0, 0, 9), 0, 1'b1, mk(9, 3, 0, 0, 1));
    n_cmp++;
    if (done_m !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done_drop: got done=%b want 0", done_m);
    end
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m, n} !== {e.mx, e.idx, e.tie, e.to, e.edge_n}) begin
      n_bad++; $display("FAIL single_result: got max=%0d idx=%0d tie=%b edge=%0d want max=%0d idx=%0d tie=%b edge=%0d",
                        max_m, idx_m, tie_m, n, e.mx, e.idx, e.tie, e.edge_n);
    end
  endtask

  task automatic test_eps_zero;
    int n;
    exp_t e;
    sel = 1;
    do_start(pk(8, 8, 0, 0), 20, 1'b1, mk(8, 0, 1, 0, 1));
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m} !== {e.mx, e.idx, e.tie, e.to}) begin
      n_bad++; $display("FAIL eps0_result: got max=%0d idx=%0d tie=%b to=%b want max=%0d idx=%0d tie=%b to=%b",
                        max_m, idx_m, tie_m, to_m, e.mx, e.idx, e.tie, e.to);
    end
    n_cmp++;
    if (n !== e.edge_n) begin
      n_bad++; $display("FAIL eps0_latency: got edge %0d want %0d", n, e.edge_n);
    end
  endtask

  task automatic test_timeout;
    int n;
    exp_t e;
    sel = 2;
`ifdef MAXNET_TIMEOUT_EN
    do_start(pk(8, 6, 4, 2), 20, 1'b1, mk(8, 0, 1, 1, 3));
`else
    do_start(pk(8, 6, 4, 2), 20, 1'b1, mk(8, 0, 0, 0, 5));
`endif
    wait_done(0, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m} !== {e.mx, e.idx, e.tie, e.to}) begin
      n_bad++; $display("FAIL timeout_result: got max=%0d idx=%0d tie=%b to=%b want max=%0d idx=%0d tie=%b to=%b",
                        max_m, idx_m, tie_m, to_m, e.mx, e.idx, e.tie, e.to);
    end
    n_cmp++;
    if (n !== e.edge_n) begin
      n_bad++; $display("FAIL timeout_latency: got edge %0d want %0d", n, e.edge_n);
    end
  endtask

  task automatic test_reset_restart;
    int n;
    exp_t e;
    sel = 0;
    do_start(pk(8, 6, 4, 2), 20, 1'b0, mk(0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy_a, done_a, max_a} !== 7'b0) begin
      n_bad++; $display("FAIL rst_midrun: got busy=%b done=%b max=%0d want all 0", busy_a, done_a, max_a);
    end
    do_start(pk(2, 4, 6, 8), 0, 1'b1, mk(8, 3, 0, 0, 5));
    wait_done(1, n);
    e = sb.pop_front();
    n_cmp++;
    if ({max_m, idx_m, tie_m, to_m} !== {e.mx, e.idx, e.tie, e.to}) begin
      n_bad++; $display("FAIL restart_result: got max=%0d idx=%0d tie=%b to=%b want max=%0d idx=%0d tie=%b to=%b",
                        max_m, idx_m, tie_m, to_m, e.mx, e.idx, e.tie, e.to);
    end
    n_cmp++;
    if (n !== e.edge_n) begin
      n_bad++; $display("FAIL restart_latency: got edge %0d want %0d", n, e.edge_n);
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_stall();
    test_back_to_back();
    test_eps_zero();
    test_timeout();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
